ascon_round_sched: RTL and testbench
====================================

ASCON_ROUND_SCHED -- requirements
Module: ascon_round_sched

Interface
REQ-001 Parameter UNROLL, default 1: permutation rounds executed per enabled cycle; legal values 1, 2, 3, 6.
REQ-002 Parameter ROUNDS_A, default 12: round count of the long permutation (p^a).
REQ-003 Parameter ROUNDS_B, default 6: round count of the short permutation (p^b).
REQ-004 Port clk_i  input  1: single clock; all state updates on its rising edge.
REQ-005 Port rst_i  input  1: reset, synchronous and active-high.
REQ-006 Port start_i  input  1: request to begin a permutation; accepted when start_i & ready_o.
REQ-007 Port sel_a_i  input  1: sampled at accept; 1 selects ROUNDS_A, 0 selects ROUNDS_B.
REQ-008 Port en_i  input  1: advance enable; 0 stalls the schedule with all state held.
REQ-009 Port abort_i  input  1: cancel any schedule in progress.
REQ-010 Port ready_o  output  1: block is idle and able to accept start_i.
REQ-011 Port busy_o  output  1: a schedule is in progress.
REQ-012 Port round_o  output  RND_WIDTH: absolute Ascon round index (0..11) of the first round in the current cycle.
REQ-013 Port pre_last_o  output  1: the current cycle is the second-to-last cycle of the schedule.
REQ-014 Port last_o  output  1: the current cycle is the final cycle of the schedule.
REQ-015 Port done_o  output  1: single-cycle pulse signalling schedule completion.
REQ-016 Port rc_o  output  UNROLL*8: round constants for round_o .. round_o+UNROLL-1, lane 0 in the LSBs; present only under the configuration macro.

Function
REQ-017 The state machine SHALL have three states: IDLE, RUN and DONE.
REQ-018 IDLE: ready_o=1 and busy_o=0; start_i=1 loads round_q = 12 - selected rounds and moves to RUN on the next edge.
REQ-019 start_i SHALL be accepted regardless of en_i; sel_a_i is ignored when start_i is not accepted.
REQ-020 RUN: busy_o=1; when en_i=1, round_q increments by UNROLL; when en_i=0, all state is held.
REQ-021 last_o SHALL equal RUN & (round_q + UNROLL == 12).
REQ-022 pre_last_o SHALL equal RUN & (round_q + 2*UNROLL == 12).
REQ-023 A schedule that takes one cycle (rounds == UNROLL) SHALL never assert pre_last_o.
REQ-024 When last_o & en_i: the next state is DONE and round_q holds its value (no increment beyond 12-UNROLL).
REQ-025 DONE: done_o=1 for exactly one cycle, busy_o=0, ready_o=0; the next state is IDLE unconditionally.
REQ-026 Latency from accept to done_o SHALL be rounds/UNROLL enabled RUN cycles plus 1 cycle.
REQ-027 abort_i=1 in any state SHALL force IDLE on the next edge, with no done_o pulse.
REQ-028 abort_i and start_i high together in IDLE: abort wins and the start is not accepted.
REQ-029 In IDLE and DONE, round_o SHALL show the held round_q, and last_o and pre_last_o SHALL be 0.
REQ-030 Round-index arithmetic SHALL be unsigned and RND_WIDTH wide; round_q never exceeds 11.
REQ-031 Elaboration SHALL fail unless 1 <= ROUNDS_B <= ROUNDS_A <= 12 and both round counts are multiples of UNROLL.

Reset
REQ-032 rst_i=1 SHALL force, on the next edge: IDLE, round_q=0, ready_o=1, busy_o=0, done_o=0, last_o=0, pre_last_o=0.
REQ-033 Reset SHALL take priority over abort_i, start_i and en_i, including in the middle of a RUN.

Configuration
REQ-034 With ASCON_ROUND_SCHED_RC_EN defined: rc_o lane k = {4'hF - i, i} with i = round_o + k, purely combinational from round_q.
REQ-035 Without ASCON_ROUND_SCHED_RC_EN: port rc_o and its generation logic SHALL be absent.

Structure
REQ-036 The package ascon_pack SHALL hold RND_WIDTH, the total round count constant 12, the state enum, and the round-constant function.
REQ-037 Round-constant generation SHALL live in a sub-module ascon_rc_gen (parameter UNROLL), instantiated only when the macro is defined.

Verification
REQ-038 Default parameters, start_i=1, sel_a_i=1 -> round_o 0..11 over 12 RUN cycles, pre_last_o at round 10, last_o at round 11, done_o one cycle later.
REQ-039 UNROLL=2, sel_a_i=0 -> round_o 6, 8, 10; last_o at 10; done_o at cycle 4 after accept.
REQ-040 en_i low for 3 cycles at round 5 -> round_o holds 5 and done_o is delayed by exactly 3 cycles.
REQ-041 abort_i at round 7 -> IDLE on the next edge, ready_o=1, no done_o pulse; abort_i together with start_i in IDLE -> stays IDLE.
REQ-042 rst_i mid-RUN at round 4 -> all outputs reach their reset values on the next edge; a subsequent start behaves normally.
REQ-043 With the macro, UNROLL=3, round_o=0 -> rc_o = {8'hD2, 8'hE1, 8'hF0}.

Source files
------------

// File: rtl/ascon_pack.sv
// Shared definitions for the Ascon round scheduler: widths, round total, FSM states, round constants.
// Latency: n/a (declarations and a pure function only).
// Backpressure: n/a.
package ascon_pack;

    // Width of the absolute round index (0..12 must be representable).
    localparam int RND_WIDTH = 4;

    // Total number of rounds in the full Ascon permutation.
    localparam int ROUNDS_TOTAL = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Round constant for absolute round i: high nibble counts down from F, low nibble counts up.
    function automatic logic [7:0] rc_byte(input logic [RND_WIDTH-1:0] i);
        return {4'hF - i, i};
    endfunction

endpackage

// File: rtl/ascon_rc_gen.sv
// Round-constant generator: one constant byte per unrolled lane, lane 0 in the LSBs.
// Latency: purely combinational from the round index.
// Backpressure: none; follows the scheduler's round index directly.
module ascon_rc_gen
    import ascon_pack::*;
#(
    parameter int UNROLL = 1
) (
    input  logic [RND_WIDTH-1:0]  round,
    output logic [UNROLL*8-1:0]   rc
);

    // One constant per lane for rounds round .. round+UNROLL-1.
    for (genvar k = 0; k < UNROLL; k++) begin : g_lane
        assign rc[k*8 +: 8] = rc_byte(round + RND_WIDTH'(k));
    end

endmodule

// File: rtl/ascon_round_sched.sv
// Ascon permutation round scheduler: IDLE -> RUN (rounds/UNROLL enabled cycles) -> DONE pulse.
// Latency: accept to done_o = rounds/UNROLL enabled RUN cycles + 1 cycle.
// Backpressure: en_i=0 freezes all state; ready_o only in IDLE. Optional rc_o under ASCON_ROUND_SCHED_RC_EN.
module ascon_round_sched
    import ascon_pack::*;
#(
    parameter int UNROLL   = 1,
    parameter int ROUNDS_A = 12,
    parameter int ROUNDS_B = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  sel_a_i,
    input  logic                  en_i,
    input  logic                  abort_i,
    output logic                  ready_o,
    output logic                  busy_o,
    output logic [RND_WIDTH-1:0]  round_o,
    output logic                  pre_last_o,
    output logic                  last_o,
    output logic                  done_o
`ifdef ASCON_ROUND_SCHED_RC_EN
    ,
    output logic [UNROLL*8-1:0]   rc_o
`endif
);

    // Refuse to build configurations the schedule cannot represent.
    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 3 || UNROLL == 6)) begin : g_bad_unroll
        $error("ascon_round_sched: UNROLL must be 1, 2, 3 or 6");
    end
    if (!(ROUNDS_B >= 1 && ROUNDS_B <= ROUNDS_A && ROUNDS_A <= ROUNDS_TOTAL)) begin : g_bad_rounds
        $error("ascon_round_sched: need 1 <= ROUNDS_B <= ROUNDS_A <= 12");
    end
    if ((ROUNDS_A % UNROLL) != 0 || (ROUNDS_B % UNROLL) != 0) begin : g_bad_multiple
        $error("ascon_round_sched: round counts must be multiples of UNROLL");
    end

    // A schedule always ends on round 11, so the start index is 12 minus its length.
    localparam logic [RND_WIDTH-1:0] START_A = RND_WIDTH'(ROUNDS_TOTAL - ROUNDS_A);
    localparam logic [RND_WIDTH-1:0] START_B = RND_WIDTH'(ROUNDS_TOTAL - ROUNDS_B);
    localparam logic [RND_WIDTH-1:0] STEP    = RND_WIDTH'(UNROLL);
    localparam logic [RND_WIDTH-1:0] STEP2   = RND_WIDTH'(2 * UNROLL);
    localparam logic [RND_WIDTH-1:0] END_IDX = RND_WIDTH'(ROUNDS_TOTAL);

    state_t                state_q;
    logic [RND_WIDTH-1:0]  round_q;
    logic                  run;
    logic                  last;
    logic                  pre_last;

    assign run = (state_q == ST_RUN);

    // Sums stay RND_WIDTH wide; for UNROLL=6 the pre-last sum wraps away from 12,
    // so a single-cycle schedule never flags pre-last.
    assign last     = run && ((round_q + STEP)  == END_IDX);
    assign pre_last = run && ((round_q + STEP2) == END_IDX);

    // Schedule state and round index; reset beats abort, abort beats everything else.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            round_q <= '0;
        end else if (abort_i) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        round_q <= sel_a_i ? START_A : START_B;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (en_i) begin
                        if (last) begin
                            state_q <= ST_DONE;
                        end else begin
                            round_q <= round_q + STEP;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready_o    = (state_q == ST_IDLE);
    assign busy_o     = run;
    assign done_o     = (state_q == ST_DONE);
    assign round_o    = round_q;
    assign last_o     = last;
    assign pre_last_o = pre_last;

`ifdef ASCON_ROUND_SCHED_RC_EN
    ascon_rc_gen #(
        .UNROLL (UNROLL)
    ) u_rc_gen (
        .round (round_q),
        .rc    (rc_o)
    );
`endif

endmodule

// File: tb/tb_ascon_round_sched.sv
// Self-checking bench for ascon_round_sched: UNROLL=1 and UNROLL=2 instances, per-cycle scoreboard.
// Latency: expected outputs are queued in the cycle they are driven and compared at the falling edge.
// Backpressure: exercises en_i stalls, abort, mid-run reset; rc_o checked when ASCON_ROUND_SCHED_RC_EN is set.
module tb_ascon_round_sched;

    typedef struct packed {
        logic       ready;
        logic       busy;
        logic [3:0] round;
        logic       pre;
        logic       last;
        logic       done;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_s [2];
    logic       sel_s   [2];
    logic       en_s    [2];
    logic       abort_s [2];
    logic       ready_s [2];
    logic       busy_s  [2];
    logic [3:0] round_s [2];
    logic       pre_s   [2];
    logic       last_s  [2];
    logic       done_s  [2];

    exp_t q0[$];
    exp_t q1[$];
    int   last_round [2];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    ascon_round_sched u_dut_u1 (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start_s[0]),
        .sel_a_i    (sel_s[0]),
        .en_i       (en_s[0]),
        .abort_i    (abort_s[0]),
        .ready_o    (ready_s[0]),
        .busy_o     (busy_s[0]),
        .round_o    (round_s[0]),
        .pre_last_o (pre_s[0]),
        .last_o     (last_s[0]),
        .done_o     (done_s[0])
`ifdef ASCON_ROUND_SCHED_RC_EN
        ,
        .rc_o       ()
`endif
    );

    ascon_round_sched #(
        .UNROLL   (2),
        .ROUNDS_A (12),
        .ROUNDS_B (6)
    ) u_dut_u2 (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start_s[1]),
        .sel_a_i    (sel_s[1]),
        .en_i       (en_s[1]),
        .abort_i    (abort_s[1]),
        .ready_o    (ready_s[1]),
        .busy_o     (busy_s[1]),
        .round_o    (round_s[1]),
        .pre_last_o (pre_s[1]),
        .last_o     (last_s[1]),
        .done_o     (done_s[1])
`ifdef ASCON_ROUND_SCHED_RC_EN
        ,
        .rc_o       ()
`endif
    );

`ifdef ASCON_ROUND_SCHED_RC_EN
    logic        start3, abort3, ready3, busy3, pre3, last3, done3;
    logic [3:0]  round3;
    logic [23:0] rc3;

    ascon_round_sched #(
        .UNROLL   (3),
        .ROUNDS_A (12),
        .ROUNDS_B (6)
    ) u_dut_u3 (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start3),
        .sel_a_i    (1'b1),
        .en_i       (1'b1),
        .abort_i    (abort3),
        .ready_o    (ready3),
        .busy_o     (busy3),
        .round_o    (round3),
        .pre_last_o (pre3),
        .last_o     (last3),
        .done_o     (done3),
        .rc_o       (rc3)
    );
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t mk(input bit rdy, input bit bsy, input int r,
                                input bit p, input bit l, input bit d);
        exp_t e;
        e.ready = rdy;
        e.busy  = bsy;
        e.round = 4'(r);
        e.pre   = p;
        e.last  = l;
        e.done  = d;
        return e;
    endfunction

    function automatic exp_t obs(input int w);
        exp_t o;
        o.ready = ready_s[w];
        o.busy  = busy_s[w];
        o.round = round_s[w];
        o.pre   = pre_s[w];
        o.last  = last_s[w];
        o.done  = done_s[w];
        return o;
    endfunction

    task automatic push(input int w, input exp_t e);
        if (w == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: each entry describes the outputs of one cycle, compared mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            check("u1_cycle {rdy,busy,round,pre,last,done}", 32'(obs(0)), 32'(e));
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check("u2_cycle {rdy,busy,round,pre,last,done}", 32'(obs(1)), 32'(e));
        end
    end

    // Drive one schedule; expected per-cycle outputs come from the step index k of n steps.
    task automatic run(input int w, input bit sel, input int stall_at, input int stall_len,
                       input int abort_at, input int rst_at);
        int u;
        int rounds;
        int n;
        int base;
        int r;
        u      = (w == 0) ? 1 : 2;
        rounds = sel ? 12 : 6;
        n      = rounds / u;
        base   = 12 - rounds;
        // Accept cycle with en low: start must not depend on en.
        start_s[w] = 1'b1;
        sel_s[w]   = sel;
        en_s[w]    = 1'b0;
        push(w, mk(1, 0, last_round[w], 0, 0, 0));
        tick();
        start_s[w] = 1'b0;
        sel_s[w]   = ~sel;
        for (int k = 0; k < n; k++) begin
            r = base + k * u;
            if (r == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    en_s[w] = 1'b0;
                    push(w, mk(0, 1, r, k == n - 2, k == n - 1, 0));
                    tick();
                end
            end
            en_s[w] = 1'b1;
            if (r == abort_at) begin
                abort_s[w] = 1'b1;
                push(w, mk(0, 1, r, k == n - 2, k == n - 1, 0));
                tick();
                abort_s[w] = 1'b0;
                en_s[w] = 1'b0;
                last_round[w] = r;
                push(w, mk(1, 0, r, 0, 0, 0));
                tick();
                return;
            end
            if (r == rst_at) begin
                rst = 1'b1;
                push(w, mk(0, 1, r, k == n - 2, k == n - 1, 0));
                tick();
                rst = 1'b0;
                en_s[w] = 1'b0;
                last_round[0] = 0;
                last_round[1] = 0;
                push(w, mk(1, 0, 0, 0, 0, 0));
                tick();
                return;
            end
            push(w, mk(0, 1, r, k == n - 2, k == n - 1, 0));
            tick();
        end
        en_s[w] = 1'b0;
        push(w, mk(0, 0, 12 - u, 0, 0, 1));
        tick();
        last_round[w] = 12 - u;
        push(w, mk(1, 0, 12 - u, 0, 0, 0));
        tick();
    endtask

    initial begin
        rst = 1'b1;
        for (int w = 0; w < 2; w++) begin
            start_s[w] = 1'b0;
            sel_s[w]   = 1'b0;
            en_s[w]    = 1'b0;
            abort_s[w] = 1'b0;
            last_round[w] = 0;
        end
`ifdef ASCON_ROUND_SCHED_RC_EN
        start3 = 1'b0;
        abort3 = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;
        push(0, mk(1, 0, 0, 0, 0, 0));
        push(1, mk(1, 0, 0, 0, 0, 0));
        tick();

        run(0, 1'b1, -1, 0, -1, -1);   // p^a, one round per cycle
        run(0, 1'b0, -1, 0, -1, -1);   // p^b, one round per cycle
        run(1, 1'b0, -1, 0, -1, -1);   // p^b, two rounds per cycle: 6, 8, 10
        run(1, 1'b1, -1, 0, -1, -1);   // p^a, two rounds per cycle
        run(0, 1'b1, 5, 3, -1, -1);    // stall three cycles at round 5
        run(0, 1'b1, -1, 0, 7, -1);    // abort at round 7

        // Abort together with start while idle: start is dropped.
        start_s[0] = 1'b1;
        sel_s[0]   = 1'b1;
        abort_s[0] = 1'b1;
        push(0, mk(1, 0, last_round[0], 0, 0, 0));
        tick();
        start_s[0] = 1'b0;
        abort_s[0] = 1'b0;
        push(0, mk(1, 0, last_round[0], 0, 0, 0));
        tick();
        push(0, mk(1, 0, last_round[0], 0, 0, 0));
        tick();

        run(0, 1'b1, -1, 0, -1, 4);    // synchronous reset mid-run at round 4
        run(0, 1'b1, -1, 0, -1, -1);   // normal schedule after reset
        run(1, 1'b0, -1, 0, -1, -1);   // other instance also recovered from reset

`ifdef ASCON_ROUND_SCHED_RC_EN
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        @(negedge clk);
        check("u3_round_first", 32'(round3), 32'd0);
        check("u3_rc_round0", 32'(rc3), 32'hD2E1F0);
        tick();
        @(negedge clk);
        check("u3_rc_round3", 32'(rc3), 32'hA5B4C3);
        abort3 = 1'b1;
        tick();
        abort3 = 1'b0;
        @(negedge clk);
        check("u3_ready_after_abort", 32'(ready3), 32'd1);
`endif

        tick();
        tick();
        check("scoreboard_drained", 32'(q0.size() + q1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
